renode_ahb_manager: RTL and testbench
=====================================

Name: renode_ahb_manager

Overview:
- AHB-Lite manager (initiator) for co-simulation benches: the counterpart of the AHB subordinate bridge.
- Accepts single read/write requests on a valid/ready command port and performs one AHB-Lite SINGLE transfer per request, honouring hready wait states and the two-cycle ERROR response.
- Returns masked read data and an error flag on a one-cycle response strobe.
- Sits between a Renode-driven request source and the AHB interconnect/subordinates under test.

Parameters:
- AddressWidth, 32, width of haddr/req_addr.
- DataWidth, 32, width of hwdata/hrdata/req_wdata/rsp_rdata; legal values 8, 16, 32, 64.

Ports:
- hclk  in  1  bus clock; all logic on its rising edge.
- hresetn  in  1  synchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted on a cycle where valid and ready are both high.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  AddressWidth  byte address.
- req_size  in  3  hsize encoding (0 = byte … 3 = doubleword).
- req_wdata  in  DataWidth  write data, already lane-positioned.
- rsp_valid  out  1  one-cycle response strobe.
- rsp_rdata  out  DataWidth  read data; inactive lanes zero; zero for writes.
- rsp_error  out  1  ERROR response, or request rejected locally.
- haddr  out  AddressWidth.
- htrans  out  2.
- hwrite  out  1.
- hsize  out  3.
- hburst  out  3  constant SINGLE.
- hprot  out  4  constant 4'b0011.
- hmastlock  out  1  constant 0.
- hwdata  out  DataWidth.
- hrdata  in  DataWidth.
- hready  in  1.
- hresp  in  1.

Behaviour:
- Reset (hresetn low at a clock edge): state IDLE; htrans = IDLE; haddr, hwrite, hsize and hwdata = 0; rsp_valid = 0; rsp_error = 0; rsp_rdata = 0. Any in-flight transfer is dropped with no response. The reset takes effect on the next edge even mid-transfer.
- States:
  - IDLE: req_ready = 1. On a handshake:
    - Local rejection: if (8 << req_size) > DataWidth, or req_addr is not aligned to the size, no bus transfer occurs. Next cycle rsp_valid = 1, rsp_error = 1; state stays IDLE.
    - Otherwise, at the next edge drive haddr/hwrite/hsize from the request, htrans = NONSEQ, and latch req_wdata; go to ADDR.
  - ADDR: req_ready = 0. Hold all address-phase outputs until the edge where hready = 1. At that edge set htrans = IDLE, drive hwdata from the latch (writes; 0 for reads), and go to DATA.
  - DATA: req_ready = 0; hwdata is held stable.
    - At an edge with hready = 1 and hresp = OKAY: capture hrdata & lane_mask for reads, rsp_error = 0, then rsp_valid = 1 next cycle; go to IDLE.
    - At an edge with hready = 0 and hresp = ERROR (first error cycle): go to ERR.
    - hready = 0 with hresp = OKAY: wait with no limit.
  - ERR: at the next edge with hready = 1 (hresp must be ERROR), emit rsp_valid = 1, rsp_error = 1, rsp_rdata = 0; go to IDLE.
  - ERR protocol violation: if hready = 0 persists, stay in ERR. If hresp returns to OKAY with hready = 0, still complete as an error.
- Latency: handshake at edge E0; address phase E0→E1; data phase E1→E2 with zero wait states; rsp_valid high in the cycle after E2. Each wait state adds 1 cycle. Minimum request-to-request spacing is 3 cycles.
- req_ready is high in the same cycle as rsp_valid, so back-to-back requests are allowed.
- Only one transfer is outstanding; address and data phases of different transfers never overlap.
- Lane mask: the byte lanes from offset = haddr[log2(DataWidth/8)-1:0] to offset + (1 << hsize) - 1 are ones; all others are zero.
- rsp_valid is a single-cycle pulse; no backpressure is applied on the response side.

Decomposition:
- Add to renode_ahb_pkg:
  - htrans encodings (Idle, Busy, NonSequential, Sequential);
  - the hresp enum (Okay, Error);
  - the hburst Single constant;
  - the hprot default constant;
  - a manager state enum (Idle, Address, Data, ErrorResponse).
- One combinational sub-module, renode_ahb_lane_mask: inputs address LSBs and hsize; outputs a DataWidth-bit mask. It is reusable by the subordinate.

Test Plan:
- Zero-wait read: req addr 'h1000, size 2, hrdata 'hDEADBEEF → NONSEQ for 1 cycle; rsp_valid in the 3rd cycle after the handshake; rsp_rdata 'hDEADBEEF; rsp_error 0.
- Write with 2 wait states: addr 'h2004, size 2, wdata 'hCAFEF00D, hready low 2 cycles in the data phase → hwdata stable for 3 cycles; rsp_valid 2 cycles later than the zero-wait case; rsp_rdata 0.
- Byte read: addr 'h3002, size 0, hrdata 'h11223344 → rsp_rdata 'h00220000.
- Two-cycle ERROR: read 'h4000; subordinate responds hready 0/ERROR, then 1/ERROR → rsp_error 1, rsp_rdata 0; htrans stays IDLE throughout.
- Local rejection: size 3 with DataWidth 32 (and separately addr 'h5001, size 2) → no NONSEQ issued; rsp_valid with rsp_error 1 in the next cycle.
- Reset mid-operation: hresetn low while in DATA with hready held low → next edge htrans IDLE, rsp_valid never asserted; after release, a read to 'h1000 completes normally.

Source files
------------

// File: rtl/renode_ahb_pkg.sv
// Shared AHB-Lite encodings and helpers for the Renode co-simulation bridges.
package renode_ahb_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    typedef enum logic {
        HRESP_OKAY  = 1'b0,
        HRESP_ERROR = 1'b1
    } hresp_e;

    localparam logic [2:0] HBURST_SINGLE = 3'b000;

    // Data access, privileged, non-bufferable, non-cacheable.
    localparam logic [3:0] HPROT_DEFAULT = 4'b0011;

    typedef enum logic [1:0] {
        MGR_IDLE = 2'b00,
        MGR_ADDR = 2'b01,
        MGR_DATA = 2'b10,
        MGR_ERR  = 2'b11
    } mgr_state_e;

    // A request is refused locally when the transfer is wider than the bus
    // or the byte address is not naturally aligned to the transfer size.
    function automatic logic req_reject(input logic [2:0] size,
                                        input logic [2:0] addr_lo,
                                        input int         data_w);
        logic bad_size;
        logic bad_align;
        bad_size = ((8 << size) > data_w);
        case (size)
            3'd0:    bad_align = 1'b0;
            3'd1:    bad_align = addr_lo[0];
            3'd2:    bad_align = |addr_lo[1:0];
            3'd3:    bad_align = |addr_lo;
            default: bad_align = 1'b1;
        endcase
        return bad_size | bad_align;
    endfunction

endpackage

// File: rtl/renode_ahb_lane_mask.sv
// Byte-lane mask for an AHB transfer: ones over the lanes the access touches.
module renode_ahb_lane_mask
    import renode_ahb_pkg::*;
#(
    parameter int DataWidth = 32,
    localparam int NumBytes = DataWidth / 8,
    localparam int OffW     = (NumBytes > 1) ? $clog2(NumBytes) : 1
) (
    input  logic [OffW-1:0]      addr_lsb,
    input  logic [2:0]           hsize,
    output logic [DataWidth-1:0] mask
);

    // Enable every byte lane in [offset, offset + bytes-in-transfer).
    always_comb begin
        int off;
        int len;
        off  = (NumBytes > 1) ? int'(addr_lsb) : 0;
        len  = 1 << hsize;
        mask = '0;
        for (int i = 0; i < NumBytes; i++) begin
            if ((i >= off) && (i < off + len)) begin
                mask[i*8 +: 8] = 8'hFF;
            end
        end
    end

endmodule

// File: rtl/renode_ahb_manager.sv
// AHB-Lite manager: turns one valid/ready request into one SINGLE transfer
// and reports the outcome on a single-cycle response strobe.
module renode_ahb_manager
    import renode_ahb_pkg::*;
#(
    parameter int AddressWidth = 32,
    parameter int DataWidth    = 32
) (
    input  logic                    hclk,
    input  logic                    hresetn,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_write,
    input  logic [AddressWidth-1:0] req_addr,
    input  logic [2:0]              req_size,
    input  logic [DataWidth-1:0]    req_wdata,
    output logic                    rsp_valid,
    output logic [DataWidth-1:0]    rsp_rdata,
    output logic                    rsp_error,
    output logic [AddressWidth-1:0] haddr,
    output logic [1:0]              htrans,
    output logic                    hwrite,
    output logic [2:0]              hsize,
    output logic [2:0]              hburst,
    output logic [3:0]              hprot,
    output logic                    hmastlock,
    output logic [DataWidth-1:0]    hwdata,
    input  logic [DataWidth-1:0]    hrdata,
    input  logic                    hready,
    input  logic                    hresp
);

    localparam int NumBytes = DataWidth / 8;
    localparam int OffW     = (NumBytes > 1) ? $clog2(NumBytes) : 1;

    mgr_state_e           state;
    htrans_e              htrans_q;
    logic [DataWidth-1:0] wdata_lat;
    logic [DataWidth-1:0] lane_mask;

    assign req_ready = (state == MGR_IDLE);
    assign htrans    = htrans_q;
    assign hburst    = HBURST_SINGLE;
    assign hprot     = HPROT_DEFAULT;
    assign hmastlock = 1'b0;

    // haddr/hsize stay on the bus through the data phase, so they select the read lanes.
    renode_ahb_lane_mask #(
        .DataWidth(DataWidth)
    ) u_lane_mask (
        .addr_lsb(haddr[OffW-1:0]),
        .hsize   (hsize),
        .mask    (lane_mask)
    );

    // Transfer sequencer: address phase, data phase, optional two-cycle error, response.
    always_ff @(posedge hclk) begin
        if (!hresetn) begin
            state     <= MGR_IDLE;
            htrans_q  <= HTRANS_IDLE;
            haddr     <= '0;
            hwrite    <= 1'b0;
            hsize     <= 3'd0;
            hwdata    <= '0;
            wdata_lat <= '0;
            rsp_valid <= 1'b0;
            rsp_error <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                MGR_IDLE: begin
                    if (req_valid) begin
                        if (req_reject(req_size, req_addr[2:0], DataWidth)) begin
                            rsp_valid <= 1'b1;
                            rsp_error <= 1'b1;
                            rsp_rdata <= '0;
                        end else begin
                            haddr     <= req_addr;
                            hwrite    <= req_write;
                            hsize     <= req_size;
                            htrans_q  <= HTRANS_NONSEQ;
                            wdata_lat <= req_wdata;
                            state     <= MGR_ADDR;
                        end
                    end
                end
                MGR_ADDR: begin
                    if (hready) begin
                        htrans_q <= HTRANS_IDLE;
                        hwdata   <= hwrite ? wdata_lat : '0;
                        state    <= MGR_DATA;
                    end
                end
                MGR_DATA: begin
                    if (hready) begin
                        // A one-cycle ERROR is a subordinate fault; still report it as an error.
                        rsp_valid <= 1'b1;
                        if (hresp == HRESP_OKAY) begin
                            rsp_error <= 1'b0;
                            rsp_rdata <= hwrite ? '0 : (hrdata & lane_mask);
                        end else begin
                            rsp_error <= 1'b1;
                            rsp_rdata <= '0;
                        end
                        state <= MGR_IDLE;
                    end else if (hresp == HRESP_ERROR) begin
                        state <= MGR_ERR;
                    end
                end
                MGR_ERR: begin
                    // Completes as an error even if hresp has dropped back to OKAY.
                    if (hready) begin
                        rsp_valid <= 1'b1;
                        rsp_error <= 1'b1;
                        rsp_rdata <= '0;
                        state     <= MGR_IDLE;
                    end
                end
                default: state <= MGR_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_renode_ahb_manager.sv
// Directed bench for renode_ahb_manager with a hand-driven AHB subordinate.
module tb_renode_ahb_manager;

    logic        hclk;
    logic        hresetn;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [2:0]  req_size;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_error;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [2:0]  hburst;
    logic [3:0]  hprot;
    logic        hmastlock;
    logic [31:0] hwdata;
    logic [31:0] hrdata;
    logic        hready;
    logic        hresp;

    int n_checks = 0;
    int n_errors = 0;

    renode_ahb_manager #(
        .AddressWidth(32),
        .DataWidth   (32)
    ) dut (
        .hclk     (hclk),
        .hresetn  (hresetn),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_write(req_write),
        .req_addr (req_addr),
        .req_size (req_size),
        .req_wdata(req_wdata),
        .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata),
        .rsp_error(rsp_error),
        .haddr    (haddr),
        .htrans   (htrans),
        .hwrite   (hwrite),
        .hsize    (hsize),
        .hburst   (hburst),
        .hprot    (hprot),
        .hmastlock(hmastlock),
        .hwdata   (hwdata),
        .hrdata   (hrdata),
        .hready   (hready),
        .hresp    (hresp)
    );

    initial hclk = 1'b0;
    always #5 hclk = ~hclk;

    task automatic tick();
        @(posedge hclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s: observed 'h%0h expected 'h%0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic wr, input logic [31:0] addr,
                         input logic [2:0] size, input logic [31:0] wdata);
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = addr;
        req_size  = size;
        req_wdata = wdata;
        tick();
        req_valid = 1'b0;
    endtask

    initial begin
        hresetn   = 1'b0;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = '0;
        req_size  = '0;
        req_wdata = '0;
        hrdata    = '0;
        hready    = 1'b1;
        hresp     = 1'b0;
        tick();
        tick();

        // Reset state
        chk("rst_htrans", htrans, 2'b00);
        chk("rst_haddr", haddr, 32'h0);
        chk("rst_hwdata", hwdata, 32'h0);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_rsp_rdata", rsp_rdata, 32'h0);
        chk("rst_req_ready", req_ready, 1'b1);
        chk("hburst", hburst, 3'b000);
        chk("hprot", hprot, 4'b0011);
        chk("hmastlock", hmastlock, 1'b0);
        hresetn = 1'b1;
        tick();

        // Zero-wait word read
        hrdata = 32'hDEADBEEF;
        issue(1'b0, 32'h1000, 3'd2, 32'h0);
        chk("rd_htrans_nonseq", htrans, 2'b10);
        chk("rd_haddr", haddr, 32'h1000);
        chk("rd_hwrite", hwrite, 1'b0);
        chk("rd_hsize", hsize, 3'd2);
        chk("rd_req_ready_busy", req_ready, 1'b0);
        tick();
        chk("rd_htrans_idle", htrans, 2'b00);
        chk("rd_rsp_early", rsp_valid, 1'b0);
        tick();
        chk("rd_rsp_valid", rsp_valid, 1'b1);
        chk("rd_rsp_rdata", rsp_rdata, 32'hDEADBEEF);
        chk("rd_rsp_error", rsp_error, 1'b0);
        chk("rd_req_ready_rsp", req_ready, 1'b1);
        tick();
        chk("rd_rsp_pulse", rsp_valid, 1'b0);

        // Word write with two data-phase wait states
        issue(1'b1, 32'h2004, 3'd2, 32'hCAFEF00D);
        chk("wr_htrans_nonseq", htrans, 2'b10);
        chk("wr_hwrite", hwrite, 1'b1);
        tick();
        chk("wr_hwdata_0", hwdata, 32'hCAFEF00D);
        chk("wr_htrans_idle", htrans, 2'b00);
        hready = 1'b0;
        tick();
        chk("wr_hwdata_1", hwdata, 32'hCAFEF00D);
        chk("wr_wait_rsp_1", rsp_valid, 1'b0);
        tick();
        chk("wr_hwdata_2", hwdata, 32'hCAFEF00D);
        chk("wr_wait_rsp_2", rsp_valid, 1'b0);
        hready = 1'b1;
        tick();
        chk("wr_rsp_valid", rsp_valid, 1'b1);
        chk("wr_rsp_rdata", rsp_rdata, 32'h0);
        chk("wr_rsp_error", rsp_error, 1'b0);
        tick();

        // Byte read from lane 2
        hrdata = 32'h11223344;
        issue(1'b0, 32'h3002, 3'd0, 32'h0);
        tick();
        tick();
        chk("byte_rsp_valid", rsp_valid, 1'b1);
        chk("byte_rsp_rdata", rsp_rdata, 32'h00220000);
        tick();

        // Halfword read from upper lanes
        hrdata = 32'hAABBCCDD;
        issue(1'b0, 32'h6002, 3'd1, 32'h0);
        tick();
        tick();
        chk("half_rsp_valid", rsp_valid, 1'b1);
        chk("half_rsp_rdata", rsp_rdata, 32'hAABB0000);
        tick();

        // Two-cycle ERROR response
        hrdata = 32'h12345678;
        issue(1'b0, 32'h4000, 3'd2, 32'h0);
        chk("err_htrans_nonseq", htrans, 2'b10);
        tick();
        hready = 1'b0;
        hresp  = 1'b1;
        tick();
        chk("err_htrans_idle", htrans, 2'b00);
        chk("err_rsp_early", rsp_valid, 1'b0);
        hready = 1'b1;
        tick();
        chk("err_rsp_valid", rsp_valid, 1'b1);
        chk("err_rsp_error", rsp_error, 1'b1);
        chk("err_rsp_rdata", rsp_rdata, 32'h0);
        chk("err_htrans_end", htrans, 2'b00);
        hresp = 1'b0;
        tick();

        // Local rejection: doubleword on a 32-bit bus
        issue(1'b0, 32'h5000, 3'd3, 32'h0);
        chk("rej_size_htrans", htrans, 2'b00);
        chk("rej_size_rsp_valid", rsp_valid, 1'b1);
        chk("rej_size_rsp_error", rsp_error, 1'b1);
        tick();
        chk("rej_size_pulse", rsp_valid, 1'b0);

        // Local rejection: misaligned word
        issue(1'b0, 32'h5001, 3'd2, 32'h0);
        chk("rej_align_htrans", htrans, 2'b00);
        chk("rej_align_rsp_valid", rsp_valid, 1'b1);
        chk("rej_align_rsp_error", rsp_error, 1'b1);
        tick();

        // Reset while stalled in the data phase
        hrdata = 32'h0BADF00D;
        issue(1'b0, 32'h1000, 3'd2, 32'h0);
        tick();
        hready = 1'b0;
        tick();
        hresetn = 1'b0;
        tick();
        chk("mid_rst_htrans", htrans, 2'b00);
        chk("mid_rst_rsp_valid", rsp_valid, 1'b0);
        chk("mid_rst_haddr", haddr, 32'h0);
        hresetn = 1'b1;
        hready  = 1'b1;
        tick();
        chk("post_rst_rsp_valid", rsp_valid, 1'b0);
        chk("post_rst_req_ready", req_ready, 1'b1);
        hrdata = 32'h55AA55AA;
        issue(1'b0, 32'h1000, 3'd2, 32'h0);
        chk("post_rst_nonseq", htrans, 2'b10);
        tick();
        tick();
        chk("post_rst_rd_valid", rsp_valid, 1'b1);
        chk("post_rst_rd_rdata", rsp_rdata, 32'h55AA55AA);
        chk("post_rst_rd_error", rsp_error, 1'b0);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
